// File: rtl/instr_stream_loader.sv
// Byte-serial instruction download receiver: frames START/count/data/END, packs 4 bytes per word, holds CPU until loaded.
// Optional LOADER_CHECKSUM_EN: XOR checksum byte expected after END_BYTE.
module instr_stream_loader #(
  parameter int          ADDR_W     = 6,
  parameter logic [7:0]  START_BYTE = 8'hFE,
  parameter logic [7:0]  END_BYTE   = 8'hFF
) (
  input  logic              clk_i,
  input  logic              reset,
  input  logic [7:0]        instr_i,
  input  logic              byte_valid_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic [ADDR_W:0]   word_count_o,
  output logic              cpu_hold_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_TAIL, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t             state, state_next;
  logic [23:0]        asm_q;
  logic [1:0]         lane_q;
  logic [CNT_W-1:0]   n_words_q;
  logic               len_too_big;
  logic               last_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]         csum_q;
`endif

  assign len_too_big = (32'(instr_i) > (32'd1 << ADDR_W));
  assign last_word   = ((word_count_o + CNT_W'(1)) == n_words_q);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // NOTE: state_next gets its default first so no path through the case can infer a latch.
  always_comb begin
    state_next = state;
    if (byte_valid_i) begin
      case (state)
        S_IDLE: if (instr_i == START_BYTE) state_next = S_LEN;
        S_LEN: begin
          if (len_too_big)          state_next = S_ERR;
          else if (instr_i == 8'h0) state_next = S_TAIL;
          else                      state_next = S_DATA;
        end
        S_DATA: if (lane_q == 2'd3 && last_word) state_next = S_TAIL;
        S_TAIL: begin
`ifdef LOADER_CHECKSUM_EN
          state_next = (instr_i == END_BYTE) ? S_CSUM : S_ERR;
`else
          state_next = (instr_i == END_BYTE) ? S_DONE : S_ERR;
`endif
        end
`ifdef LOADER_CHECKSUM_EN
        S_CSUM: state_next = (instr_i == csum_q) ? S_DONE : S_ERR;
`endif
        S_DONE, S_ERR: if (instr_i == START_BYTE) state_next = S_LEN;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Markers are not decoded in DATA, so FE/FF bytes inside the payload are ordinary data.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      imem_we_o    <= 1'b0;
      imem_addr_o  <= '0;
      imem_wdata_o <= '0;
      word_count_o <= '0;
      asm_q        <= '0;
      lane_q       <= '0;
      n_words_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      imem_we_o <= 1'b0;
      if (byte_valid_i) begin
        case (state)
          S_LEN: begin
            word_count_o <= '0;
            lane_q       <= '0;
            n_words_q    <= CNT_W'(instr_i);
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
          end
          S_DATA: begin
            lane_q <= lane_q + 2'd1;
            asm_q  <= {asm_q[15:0], instr_i};
`ifdef LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ instr_i;
`endif
            if (lane_q == 2'd3) begin
              imem_we_o    <= 1'b1;
              imem_wdata_o <= {asm_q, instr_i};
              imem_addr_o  <= word_count_o[ADDR_W-1:0];
              word_count_o <= word_count_o + CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign done_o     = (state == S_DONE);
  assign err_o      = (state == S_ERR);
  assign cpu_hold_o = (state != S_DONE);

endmodule

// File: tb/tb_instr_stream_loader.sv
// Directed-vector bench for instr_stream_loader; define LOADER_CHECKSUM_EN to also cover the checksum byte.
module tb_instr_stream_loader;

  localparam int ADDR_W = 6;

  logic              clk;
  logic              rst;
  logic [7:0]        instr;
  logic              byte_valid;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   word_count;
  logic              cpu_hold;
  logic              done;
  logic              err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]        tx_q[$];
  logic [ADDR_W-1:0] wa_q[$];
  logic [31:0]       wd_q[$];

  instr_stream_loader #(.ADDR_W(ADDR_W)) dut (
    .clk_i        (clk),
    .reset        (rst),
    .instr_i      (instr),
    .byte_valid_i (byte_valid),
    .imem_we_o    (imem_we),
    .imem_addr_o  (imem_addr),
    .imem_wdata_o (imem_wdata),
    .word_count_o (word_count),
    .cpu_hold_o   (cpu_hold),
    .done_o       (done),
    .err_o        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write log: a strobe longer than one cycle shows up as an extra entry.
  always @(negedge clk) begin
    if (imem_we) begin
      wa_q.push_back(imem_addr);
      wd_q.push_back(imem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_write(input int idx, input logic [31:0] addr, input logic [31:0] data);
    if (wa_q.size() > idx) begin
      check("wr_addr", 32'(wa_q[idx]), addr);
      check("wr_data", wd_q[idx], data);
    end else begin
      check("wr_missing", $unsigned(wa_q.size()), $unsigned(idx + 1));
    end
  endtask

  // Drive one byte starting from a negedge; returns at the negedge after it was sampled.
  task automatic send_byte(input logic [7:0] b);
    instr      = b;
    byte_valid = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
    instr      = 8'h00;
  endtask

  task automatic send_q(input int gap, input int data_words);
    for (int i = 0; i < tx_q.size(); i++) begin
      send_byte(tx_q[i]);
      if (i >= 2 && i < 2 + 4 * data_words && ((i - 2) % 4) == 3)
        check("we_latency", 32'(imem_we), 32'd1);
      repeat (gap) @(negedge clk);
    end
    tx_q.delete();
  endtask

  task automatic send_tail(input int gap, input logic [7:0] csum);
    send_byte(8'hFF);
`ifdef LOADER_CHECKSUM_EN
    repeat (gap) @(negedge clk);
    send_byte(csum);
`else
    if (csum != csum) $display("unreachable");
`endif
  endtask

  task automatic do_reset();
    byte_valid = 1'b0;
    instr      = 8'h00;
    rst        = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic load_frame1(input int gap);
    tx_q = '{8'hFE, 8'h02, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h01, 8'h13};
    send_q(gap, 2);
    send_tail(gap, 8'h71);
  endtask

  task automatic check_frame1(input string tag);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_wcount"}, 32'(word_count), 32'd2);
    check({tag, "_nwrites"}, $unsigned(wa_q.size()), 32'd2);
    check_write(0, 32'd0, 32'h00500093);
    check_write(1, 32'd1, 32'h00A00113);
  endtask

  initial begin
    rst        = 1'b1;
    byte_valid = 1'b0;
    instr      = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_wcount", 32'(word_count), 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    do_reset();

    // Test 1: basic two-word frame
    load_frame1(0);
    check_frame1("t1");
    repeat (3) @(negedge clk);
    check("t1_done_level", 32'(done), 32'd1);
    check("t1_addr_hold", 32'(imem_addr), 32'd1);
    check("t1_wdata_hold", imem_wdata, 32'h00A00113);

    // Test 2: noise in IDLE, then the same frame
    do_reset();
    tx_q = '{8'h00, 8'h12, 8'hFF};
    send_q(0, 0);
    check("t2_noise_writes", $unsigned(wa_q.size()), 32'd0);
    check("t2_noise_done", 32'(done), 32'd0);
    check("t2_noise_hold", 32'(cpu_hold), 32'd1);
    load_frame1(0);
    check_frame1("t2");

    // Test 3: marker values inside the payload are data
    do_reset();
    tx_q = '{8'hFE, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    send_q(0, 1);
    send_tail(0, 8'h00);
    check("t3_done", 32'(done), 32'd1);
    check("t3_nwrites", $unsigned(wa_q.size()), 32'd1);
    check_write(0, 32'd0, 32'hFFFFFFFF);

    // Zero-length frame goes straight to the tail
    do_reset();
    tx_q = '{8'hFE, 8'h00};
    send_q(0, 0);
    send_tail(0, 8'h00);
    check("t3z_done", 32'(done), 32'd1);
    check("t3z_wcount", 32'(word_count), 32'd0);
    check("t3z_nwrites", $unsigned(wa_q.size()), 32'd0);

    // Test 4a: wrong tail byte
    do_reset();
    tx_q = '{8'hFE, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
    send_q(0, 1);
    check("t4a_err", 32'(err), 32'd1);
    check("t4a_done", 32'(done), 32'd0);
    check("t4a_hold", 32'(cpu_hold), 32'd1);
    check_write(0, 32'd0, 32'h11223344);

    // Test 4b: count above capacity, sticky error, recovery
    do_reset();
    tx_q = '{8'hFE, 8'h41};
    send_q(0, 0);
    check("t4b_err", 32'(err), 32'd1);
    check("t4b_hold", 32'(cpu_hold), 32'd1);
    tx_q = '{8'h12, 8'hFF, 8'h00};
    send_q(1, 0);
    check("t4b_sticky", 32'(err), 32'd1);
    check("t4b_nwrites", $unsigned(wa_q.size()), 32'd0);
    send_byte(8'hFE);
    check("t4b_clear", 32'(err), 32'd0);
    tx_q = '{8'h02, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h01, 8'h13};
    send_q(0, 0);
    send_tail(0, 8'h71);
    check_frame1("t4b");

    // Test 5: gaps of 3 idle cycles between every byte
    do_reset();
    load_frame1(3);
    check_frame1("t5");

    // Test 5b: reset after 2nd byte of word 1 drops the partial word
    do_reset();
    tx_q = '{8'hFE, 8'h02, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0};
    send_q(0, 1);
    #2 rst = 1'b1;
    #1;
    check("t5b_hold_async", 32'(cpu_hold), 32'd1);
    check("t5b_done_async", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tx_q = '{8'h01, 8'h13, 8'hFF};
    send_q(0, 0);
    repeat (2) @(negedge clk);
    check("t5b_nwrites", $unsigned(wa_q.size()), 32'd1);
    check("t5b_done", 32'(done), 32'd0);
    check("t5b_hold", 32'(cpu_hold), 32'd1);

`ifdef LOADER_CHECKSUM_EN
    // Test 6: checksum byte mismatch
    do_reset();
    tx_q = '{8'hFE, 8'h02, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h01, 8'h13};
    send_q(0, 2);
    send_tail(0, 8'h70);
    check("t6_err", 32'(err), 32'd1);
    check("t6_done", 32'(done), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
